// File: rtl/gpio_regbank.sv
// GPIO register bank: word-addressed control/status registers, two-flop pin
// synchroniser, per-bit edge detection, sticky W1C interrupt status and a registered read port.
module gpio_regbank #(
    parameter int unsigned GPIO_W       = 16,
    parameter logic [31:0] CHIP_NAME    = 32'h48524a44,
    parameter logic [31:0] CHIP_VERSION = 32'h00000002
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              r_wn,
    input  logic [3:0]        addr,
    input  logic [3:0]        wben,
    input  logic [31:0]       wdata,
    input  logic [GPIO_W-1:0] gpio_pin_in,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [GPIO_W-1:0] rf_gpio_datareg,
    output logic [GPIO_W-1:0] rf_gpio_tristate,
    output logic [GPIO_W-1:0] rf_gpio_interrupt_mask,
    output logic              irq
);

    localparam logic [3:0] A_NAME    = 4'h0;
    localparam logic [3:0] A_VERSION = 4'h1;
    localparam logic [3:0] A_TRIS    = 4'h2;
    localparam logic [3:0] A_PINS    = 4'h3;
    localparam logic [3:0] A_MASK    = 4'h4;
    localparam logic [3:0] A_DATA    = 4'h5;
    localparam logic [3:0] A_SCRATCH = 4'h6;
    localparam logic [3:0] A_RISE    = 4'h7;
    localparam logic [3:0] A_FALL    = 4'h8;
    localparam logic [3:0] A_STATUS  = 4'h9;
    localparam logic [3:0] A_SET     = 4'hA;
    localparam logic [3:0] A_CLR     = 4'hB;

    logic [GPIO_W-1:0] tristate_q, tristate_d;
    logic [GPIO_W-1:0] mask_q, mask_d;
    logic [GPIO_W-1:0] data_q, data_d;
    logic [31:0]       scratch_q, scratch_d;
    logic [GPIO_W-1:0] rise_en_q, rise_en_d;
    logic [GPIO_W-1:0] fall_en_q, fall_en_d;
    logic [GPIO_W-1:0] status_q, status_d;
    logic [GPIO_W-1:0] s1_q, s2_q, prev_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;

    logic              wr_en;
    logic              rd_en;
    logic [31:0]       lane_m;
    logic [GPIO_W-1:0] lane_g;
    logic [GPIO_W-1:0] bits_g;
    logic [GPIO_W-1:0] edge_ev;
    logic [31:0]       rd_mux;

    assign wr_en  = req & ~r_wn;
    assign rd_en  = req & r_wn;
    assign lane_m = {{8{wben[3]}}, {8{wben[2]}}, {8{wben[1]}}, {8{wben[0]}}};
    assign lane_g = lane_m[GPIO_W-1:0];
    assign bits_g = wdata[GPIO_W-1:0] & lane_g;

    // Read data mux; write-only and unmapped words read as zero
    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            A_NAME:    rd_mux = CHIP_NAME;
            A_VERSION: rd_mux = CHIP_VERSION;
            A_TRIS:    rd_mux = 32'(tristate_q);
            A_PINS:    rd_mux = 32'(s2_q);
            A_MASK:    rd_mux = 32'(mask_q);
            A_DATA:    rd_mux = 32'(data_q);
            A_SCRATCH: rd_mux = scratch_q;
            A_RISE:    rd_mux = 32'(rise_en_q);
            A_FALL:    rd_mux = 32'(fall_en_q);
            A_STATUS:  rd_mux = 32'(status_q);
            default:   rd_mux = 32'h0;
        endcase
    end

    // Next-state for the register file; a new edge overrides a same-cycle W1C
    always_comb begin
        tristate_d = tristate_q;
        mask_d     = mask_q;
        data_d     = data_q;
        scratch_d  = scratch_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_d   = status_q;
        edge_ev    = (s2_q & ~prev_q & rise_en_q) | (~s2_q & prev_q & fall_en_q);
        if (wr_en) begin
            case (addr)
                A_TRIS:    tristate_d = (tristate_q & ~lane_g) | bits_g;
                A_MASK:    mask_d     = (mask_q & ~lane_g) | bits_g;
                A_DATA:    data_d     = (data_q & ~lane_g) | bits_g;
                A_SCRATCH: scratch_d  = (scratch_q & ~lane_m) | (wdata & lane_m);
                A_RISE:    rise_en_d  = (rise_en_q & ~lane_g) | bits_g;
                A_FALL:    fall_en_d  = (fall_en_q & ~lane_g) | bits_g;
                A_STATUS:  status_d   = status_q & ~bits_g;
                A_SET:     data_d     = data_q | bits_g;
                A_CLR:     data_d     = data_q & ~bits_g;
                default:   ;
            endcase
        end
        status_d = status_d | edge_ev;
        rvalid_d = rd_en;
        rdata_d  = rd_en ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tristate_q <= '0;
            mask_q     <= '0;
            data_q     <= '0;
            scratch_q  <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
        end else begin
            tristate_q <= tristate_d;
            mask_q     <= mask_d;
            data_q     <= data_d;
            scratch_q  <= scratch_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            s1_q       <= gpio_pin_in;
            s2_q       <= s1_q;
            prev_q     <= s2_q;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign rdata                  = rdata_q;
    assign rvalid                 = rvalid_q;
    assign rf_gpio_datareg        = data_q;
    assign rf_gpio_tristate       = tristate_q;
    assign rf_gpio_interrupt_mask = mask_q;
    assign irq                    = |(status_q & mask_q);

endmodule

// File: tb/tb_gpio_regbank.sv
// Bench for gpio_regbank: directed scenarios plus randomized bus/pin traffic
// compared against a pin-history reference model.
module tb_gpio_regbank;

    localparam int unsigned GPIO_W = 16;

    logic              clk;
    logic              reset;
    logic              req;
    logic              r_wn;
    logic [3:0]        addr;
    logic [3:0]        wben;
    logic [31:0]       wdata;
    logic [GPIO_W-1:0] gpio_pin_in;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [GPIO_W-1:0] rf_gpio_datareg;
    logic [GPIO_W-1:0] rf_gpio_tristate;
    logic [GPIO_W-1:0] rf_gpio_interrupt_mask;
    logic              irq;

    int checks = 0;
    int errors = 0;

    gpio_regbank #(.GPIO_W(GPIO_W)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .req                    (req),
        .r_wn                   (r_wn),
        .addr                   (addr),
        .wben                   (wben),
        .wdata                  (wdata),
        .gpio_pin_in            (gpio_pin_in),
        .rdata                  (rdata),
        .rvalid                 (rvalid),
        .rf_gpio_datareg        (rf_gpio_datareg),
        .rf_gpio_tristate       (rf_gpio_tristate),
        .rf_gpio_interrupt_mask (rf_gpio_interrupt_mask),
        .irq                    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents plus the last three sampled pin values
    logic [GPIO_W-1:0] m_tri, m_mask, m_data, m_rise, m_fall, m_status;
    logic [31:0]       m_scratch, m_rdata;
    logic              m_rvalid;
    logic [GPIO_W-1:0] hist [3];
    logic [GPIO_W-1:0] pin_v;

    function automatic void model_reset();
        m_tri = '0; m_mask = '0; m_data = '0; m_rise = '0; m_fall = '0; m_status = '0;
        m_scratch = '0; m_rdata = '0; m_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) hist[i] = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [3:0] a);
        case (a)
            4'h0: return 32'h48524a44;
            4'h1: return 32'h00000002;
            4'h2: return 32'(m_tri);
            4'h3: return 32'(hist[1]);
            4'h4: return 32'(m_mask);
            4'h5: return 32'(m_data);
            4'h6: return m_scratch;
            4'h7: return 32'(m_rise);
            4'h8: return 32'(m_fall);
            4'h9: return 32'(m_status);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic model_irq();
        return |(m_status & m_mask);
    endfunction

    // One bus cycle: drive, clock, advance the model, settle 1ns past the edge
    task automatic cycle(input logic rq, input logic rw, input logic [3:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        logic [31:0]       lm;
        logic [31:0]       rv;
        logic [GPIO_W-1:0] bits, ev;
        req = rq; r_wn = rw; addr = a; wben = be; wdata = wd; gpio_pin_in = pin_v;
        @(posedge clk);
        lm = '0;
        for (int b = 0; b < 4; b++) if (be[b]) lm[8*b +: 8] = 8'hFF;
        bits = wd[GPIO_W-1:0] & lm[GPIO_W-1:0];
        ev = (hist[1] & ~hist[0] & m_rise) | (~hist[1] & hist[0] & m_fall);
        rv = model_read(a);
        if (rq && !rw) begin
            case (a)
                4'h2: m_tri  = (m_tri  & ~lm[GPIO_W-1:0]) | bits;
                4'h4: m_mask = (m_mask & ~lm[GPIO_W-1:0]) | bits;
                4'h5: m_data = (m_data & ~lm[GPIO_W-1:0]) | bits;
                4'h6: m_scratch = (m_scratch & ~lm) | (wd & lm);
                4'h7: m_rise = (m_rise & ~lm[GPIO_W-1:0]) | bits;
                4'h8: m_fall = (m_fall & ~lm[GPIO_W-1:0]) | bits;
                4'h9: m_status = m_status & ~bits;
                4'hA: m_data = m_data | bits;
                4'hB: m_data = m_data & ~bits;
                default: ;
            endcase
        end
        m_status = m_status | ev;
        m_rvalid = rq && rw;
        if (m_rvalid) m_rdata = rv;
        hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = pin_v;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 0; r_wn = 0; addr = 0; wben = 0; wdata = 0;
        pin_v = '0; gpio_pin_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        checks++; if (rf_gpio_datareg !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", rf_gpio_datareg); end
        checks++; if (rf_gpio_tristate !== '0) begin errors++; $display("FAIL reset_tri got %h exp 0", rf_gpio_tristate); end
        checks++; if (rf_gpio_interrupt_mask !== '0) begin errors++; $display("FAIL reset_mask got %h exp 0", rf_gpio_interrupt_mask); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq); end
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_id_regs();
        cycle(1'b1, 1'b1, 4'h0, 4'h0, 32'h0);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h48524a44) begin errors++; $display("FAIL id_name got %b/%h exp 1/48524a44", rvalid, rdata); end
        cycle(1'b1, 1'b1, 4'h1, 4'h0, 32'h0);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h00000002) begin errors++; $display("FAIL id_version got %b/%h exp 1/00000002", rvalid, rdata); end
        cycle(1'b1, 1'b1, 4'hC, 4'h0, 32'h0);
        checks++; if (rvalid !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL id_unmapped got %b/%h exp 1/0", rvalid, rdata); end
        idle(1);
        checks++; if (rvalid !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL id_hold got %b/%h exp 0/0", rvalid, rdata); end
    endtask

    task automatic test_byte_lanes();
        cycle(1'b1, 1'b0, 4'h6, 4'b0101, 32'hA5A5A5A5);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL write_no_rvalid got %b exp 0", rvalid); end
        cycle(1'b1, 1'b1, 4'h6, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h00A500A5) begin errors++; $display("FAIL scratch_lanes got %h exp 00a500a5", rdata); end
        cycle(1'b1, 1'b0, 4'h5, 4'hF, 32'hFFFF_FFFF);
        checks++; if (rf_gpio_datareg !== 16'hFFFF) begin errors++; $display("FAIL data_out got %h exp ffff", rf_gpio_datareg); end
        cycle(1'b1, 1'b1, 4'h5, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h0000FFFF) begin errors++; $display("FAIL data_width got %h exp 0000ffff", rdata); end
        cycle(1'b1, 1'b0, 4'h5, 4'b1100, 32'h0000_0000);
        checks++; if (rf_gpio_datareg !== 16'hFFFF) begin errors++; $display("FAIL upper_lanes got %h exp ffff", rf_gpio_datareg); end
    endtask

    task automatic test_set_clr();
        cycle(1'b1, 1'b0, 4'h5, 4'hF, 32'h0000_00F0);
        cycle(1'b1, 1'b0, 4'hA, 4'hF, 32'h0000_0003);
        checks++; if (rf_gpio_datareg !== 16'h00F3) begin errors++; $display("FAIL w1s got %h exp 00f3", rf_gpio_datareg); end
        cycle(1'b1, 1'b0, 4'hB, 4'hF, 32'h0000_00F0);
        checks++; if (rf_gpio_datareg !== 16'h0003) begin errors++; $display("FAIL w1c_data got %h exp 0003", rf_gpio_datareg); end
        cycle(1'b1, 1'b0, 4'hA, 4'b0010, 32'h0000_FFFF);
        checks++; if (rf_gpio_datareg !== 16'hFF03) begin errors++; $display("FAIL w1s_lane got %h exp ff03", rf_gpio_datareg); end
        cycle(1'b1, 1'b1, 4'hA, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL set_read got %h exp 0", rdata); end
    endtask

    task automatic test_rise_irq();
        cycle(1'b1, 1'b0, 4'h7, 4'hF, 32'h1);
        cycle(1'b1, 1'b0, 4'h4, 4'hF, 32'h1);
        cycle(1'b1, 1'b0, 4'h8, 4'hF, 32'h0);
        cycle(1'b1, 1'b0, 4'h9, 4'hF, 32'hFFFF);
        pin_v = 16'h0001;
        idle(1);
        idle(1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_early got %b exp 0", irq); end
        idle(1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq got %b exp 1", irq); end
        cycle(1'b1, 1'b1, 4'h9, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL rise_status got %h exp 1", rdata); end
        cycle(1'b1, 1'b1, 4'h3, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL pinstate got %h exp 1", rdata); end
        cycle(1'b1, 1'b0, 4'h9, 4'hF, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq got %b exp 0", irq); end
        pin_v = 16'h0000;
        idle(4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_dis_irq got %b exp 0", irq); end
        cycle(1'b1, 1'b1, 4'h9, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL fall_dis_status got %h exp 0", rdata); end
    endtask

    task automatic test_w1c_race();
        pin_v = 16'h0001;
        idle(2);
        cycle(1'b1, 1'b0, 4'h9, 4'hF, 32'h1);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_irq got %b exp 1", irq); end
        cycle(1'b1, 1'b1, 4'h9, 4'h0, 32'h0);
        checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL race_status got %h exp 1", rdata); end
        cycle(1'b1, 1'b0, 4'h9, 4'hF, 32'h1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_clear got %b exp 0", irq); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) pin_v = GPIO_W'($urandom);
            cycle(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom);
            checks++; if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid cyc %0d got %b exp %b", i, rvalid, m_rvalid); end
            checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d got %h exp %h", i, rdata, m_rdata); end
            checks++; if (rf_gpio_datareg !== m_data) begin errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", i, rf_gpio_datareg, m_data); end
            checks++; if (rf_gpio_tristate !== m_tri) begin errors++; $display("FAIL rnd_tri cyc %0d got %h exp %h", i, rf_gpio_tristate, m_tri); end
            checks++; if (rf_gpio_interrupt_mask !== m_mask) begin errors++; $display("FAIL rnd_mask cyc %0d got %h exp %h", i, rf_gpio_interrupt_mask, m_mask); end
            checks++; if (irq !== model_irq()) begin errors++; $display("FAIL rnd_irq cyc %0d got %b exp %b", i, irq, model_irq()); end
        end
    endtask

    task automatic test_async_reset();
        pin_v = 16'h0000;
        idle(3);
        cycle(1'b1, 1'b0, 4'h7, 4'hF, 32'hFFFF);
        cycle(1'b1, 1'b0, 4'h4, 4'hF, 32'hFFFF);
        cycle(1'b1, 1'b0, 4'h5, 4'hF, 32'h5A5A);
        cycle(1'b1, 1'b0, 4'h9, 4'hF, 32'hFFFF);
        pin_v = 16'hFFFF;
        idle(3);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
        req = 1'b1; r_wn = 1'b1; addr = 4'h6;
        #3;
        reset = 1'b1;
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq got %b exp 0", irq); end
        checks++; if (rf_gpio_datareg !== '0 || rf_gpio_tristate !== '0 || rf_gpio_interrupt_mask !== '0) begin
            errors++; $display("FAIL async_outs got %h/%h/%h exp 0/0/0", rf_gpio_datareg, rf_gpio_tristate, rf_gpio_interrupt_mask); end
        checks++; if (rdata !== 32'h0 || rvalid !== 1'b0) begin errors++; $display("FAIL async_rd got %h/%b exp 0/0", rdata, rvalid); end
        @(posedge clk);
        #1;
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL abort_rvalid got %b exp 0", rvalid); end
        req = 1'b0;
        reset = 1'b0;
        model_reset();
        pin_v = '0;
        idle(1);
        checks++; if (rvalid !== 1'b0 || irq !== 1'b0) begin errors++; $display("FAIL post_reset got %b/%b exp 0/0", rvalid, irq); end
    endtask

    initial begin
        test_reset();
        test_id_regs();
        test_byte_lanes();
        test_set_clr();
        test_rise_irq();
        test_w1c_race();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_regbank.md
# gpio_regbank

Parametrised, second-generation GPIO register bank for the RISC-V microcontroller peripheral bus. It gives software a word-addressed register space for a GPIO port of configurable width. It adds a two-flop input synchroniser, per-bit rising/falling edge detection, sticky write-1-to-clear interrupt status, atomic set/clear of the data register, and a registered read path with a valid strobe. The block sits between the bus decoder and the GPIO pad ring and drives one interrupt line to the core.

## Interface
- GPIO_W, 16, port width in bits, legal 1..32
- CHIP_NAME, 32'h48524a44, value returned at word 0x0
- CHIP_VERSION, 32'h00000002, value returned at word 0x1 (Major, Minor, Bugfix, Development bytes)
- clk  in  1  master clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  bus access strobe, one cycle per access
- r_wn  in  1  1 = read, 0 = write; sampled only when req=1
- addr  in  4 ([5:2])  word address
- wben  in  4  write byte enables, bit n covers wdata[8n+7:8n]
- wdata  in  32  write data
- gpio_pin_in  in  GPIO_W  asynchronous pad inputs
- rdata  out  32  registered read data
- rvalid  out  1  one-cycle pulse, rdata valid
- rf_gpio_datareg  out  GPIO_W  output data to pads
- rf_gpio_tristate  out  GPIO_W  per-pin output enable/tristate control
- rf_gpio_interrupt_mask  out  GPIO_W  per-pin interrupt enable
- irq  out  1  level interrupt to core

## Operation
- Word map: 0x0 name (RO), 0x1 version (RO), 0x2 tristate (RW), 0x3 pinstate (RO, synchronised value), 0x4 interrupt mask (RW), 0x5 datareg (RW), 0x6 scratch (RW, full 32 bits), 0x7 rise_en (RW), 0x8 fall_en (RW), 0x9 irq_status (RO/W1C), 0xA datareg_set (WO, W1S), 0xB datareg_clr (WO, W1C). 0xC–0xF read 0, writes ignored.
- GPIO_W-wide fields occupy bits [GPIO_W-1:0]. Upper bits read 0 and ignore writes.
- Byte lanes apply per wben bit on every writable word, including the W1C and W1S words. A lane entirely above GPIO_W has no effect.
- Reads of 0xA/0xB return 0. Writes to RO words are ignored.
- Synchroniser: s1<=pin, s2<=s1, prev<=s2.
- rise[i] = s2[i] & ~prev[i] & rise_en[i]. fall[i] = ~s2[i] & prev[i] & fall_en[i].
- Status bit i is set on rise[i] | fall[i], independent of mask. It clears only by writing 1 to 0x9.
- irq = |(irq_status & rf_gpio_interrupt_mask), decoded from flops.

## Timing
- Reset (asynchronous): all RW registers, scratch, s1/s2/prev, irq_status, rdata, rvalid are 0. Hence irq=0, and every output is 0.
- Reads: when req & r_wn are high at edge k, rdata is loaded at edge k, with rvalid=1 for cycle k..k+1. rdata holds until the next read. rvalid=0 whenever no read was sampled.
- Writes: when req & ~r_wn are high at edge k, the register updates at edge k. A read at edge k+1 returns the new value. Writes produce no rvalid.
- Input latency: a pin change that is stable before edge k appears in s2 after edge k+1. It is readable at 0x3 by a read sampled at edge k+2. The status bit is set at edge k+2 and irq rises in the same cycle.
- Simultaneous W1C of status bit i and a new edge on bit i in the same cycle: the set wins and the bit stays 1.
- Simultaneous edges on different bits all latch. A W1C clears only the bits written with 1.
- Enabling rise_en while the pin is already high causes no event. An event occurs only on an s2/prev transition.
- Pins held high through reset release: s2 rises at edge 2 after release. This sets status only if rise_en was already written by then.
- A reset asserted mid-access aborts it. No rvalid follows.

## Test plan
- Reset then read 0x0, 0x1, 0xC -> 32'h48524a44, 32'h00000002, 0. Each returns rvalid one cycle after the req edge.
- Write 0x6 with wdata 32'hA5A5A5A5 and wben 4'b0101, then read -> 32'h00A500A5. Write 0x5 with 32'hFFFF_FFFF, then read -> 32'h0000FFFF (GPIO_W=16).
- With datareg=16'h00F0: write 0xA with 16'h0003 -> 16'h00F3. Then write 0xB with 16'h00F0 -> 16'h0003. rf_gpio_datareg follows within one cycle of each write.
- Set rise_en=1, mask=1 and drive pin0 0->1 before edge k -> irq_status=1 and irq=1 after edge k+2. Write 1 to 0x9 -> irq=0 next cycle. Repeat with fall_en=0 and pin0 1->0 -> no status.
- Set rise_en=1 and schedule the W1C of bit 0 on the same edge that the pin0 rise is detected -> status bit stays 1 and irq stays high.
- Assert reset asynchronously between edges while status=1, mask=1 -> irq and all outputs go 0 immediately without waiting for a clock edge.
